// File: rtl/echo_result_filter_pkg.sv
// Shared widths and constants for the echo distance result filter.
// The sample_t record is the stage-1 capture of the counter result.
package echo_result_filter_pkg;

   localparam int BCD_DIGITS = 3;
   localparam int BCD_W      = 12;
   localparam int BIN_W      = 10;
   localparam int BCD_MAX    = 999;
   localparam logic [BCD_W-1:0] FLUSH_BCD = 12'h000;

   typedef struct packed {
      logic [BCD_W-1:0] bcd;
      logic             echo;
      logic             live;
   } sample_t;

   function automatic logic [BIN_W-1:0] abs_diff(input logic [BIN_W-1:0] a,
                                                 input logic [BIN_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/echo_result_filter_bcd_bin_to_bcd.sv
// Combinational double-dabble: 10-bit binary to three BCD digits.
// Inputs above 999 saturate so the display never shows a wrapped value.
module bcd_bin_to_bcd
   import echo_result_filter_pkg::*;
(
   input  logic [BIN_W-1:0] bin_in,
   output logic [BCD_W-1:0] bcd_out
);

   logic [BIN_W-1:0]       bin_sat;
   logic [BCD_W+BIN_W-1:0] sr;

   always_comb begin
      bin_sat = (bin_in > BIN_W'(BCD_MAX)) ? BIN_W'(BCD_MAX) : bin_in;
      sr = '0;
      sr[BIN_W-1:0] = bin_sat;
      for (int i = 0; i < BIN_W; i++) begin
         for (int d = 0; d < BCD_DIGITS; d++) begin
            if (sr[BIN_W+4*d +: 4] >= 4'd5)
               sr[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] + 4'd3;
         end
         sr = sr << 1;
      end
      bcd_out = sr[BIN_W +: BCD_W];
   end

endmodule

// File: rtl/echo_result_filter.sv
// Echo distance result filter: captures one counter result per clk_34 edge,
// rejects bad readings and drives a moving average over the last DEPTH samples.
module echo_result_filter
   import echo_result_filter_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int MIN_CM     = 2,
   parameter int MAX_CM     = 400,
   parameter int MISS_LIMIT = 3,
   parameter int JUMP_CM    = 50
)(
   input  logic             clk_34,
   input  logic             reset,
   input  logic [BCD_W-1:0] show_bcd,
   input  logic             echo_valid,
   output logic [BCD_W-1:0] dist_bcd,
   output logic             dist_valid,
   output logic             out_of_range,
   output logic [4:0]       fill_level
);

   localparam int L      = $clog2(DEPTH);
   localparam int SUM_W  = BIN_W + L;
   localparam int MISS_W = $clog2(MISS_LIMIT + 1);

   localparam logic [BIN_W-1:0]  MIN_B    = BIN_W'(MIN_CM);
   localparam logic [BIN_W-1:0]  MAX_B    = BIN_W'(MAX_CM);
   localparam logic [BIN_W:0]    JUMP_B   = (BIN_W+1)'(JUMP_CM);
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);
   localparam logic [4:0]        DEPTH_F  = 5'(DEPTH);

   sample_t smp_q, smp_d;

   logic [BIN_W-1:0]  hist_q [DEPTH];
   logic [BIN_W-1:0]  hist_d [DEPTH];
   logic [L-1:0]      wr_ptr_q, wr_ptr_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [4:0]        fill_q, fill_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic [BCD_W-1:0]  dist_bcd_q, dist_bcd_d;
   logic              dist_valid_q, dist_valid_d;
   logic              oor_q, oor_d;

   logic [3:0]        d2, d1, d0;
   logic              digits_ok;
   logic [BIN_W-1:0]  bin;
   logic              acc;
   logic              full;
   logic [BIN_W-1:0]  avg_cur;
   logic              jump;
   logic              upd_avg;
   logic              flush;
   logic [BIN_W-1:0]  avg_new;
   logic [BCD_W-1:0]  avg_bcd;

   // Stage 1: capture; live marks a real sample, so the post-reset bubble is not a miss
   always_comb begin
      smp_d.bcd  = show_bcd;
      smp_d.echo = echo_valid;
      smp_d.live = 1'b1;
   end

   assign d2 = smp_q.bcd[11:8];
   assign d1 = smp_q.bcd[7:4];
   assign d0 = smp_q.bcd[3:0];
   assign digits_ok = (d2 <= 4'd9) && (d1 <= 4'd9) && (d0 <= 4'd9);
   assign bin = BIN_W'(d2) * BIN_W'(100) + BIN_W'(d1) * BIN_W'(10) + BIN_W'(d0);
   assign acc = smp_q.live && smp_q.echo && digits_ok && (bin >= MIN_B) && (bin <= MAX_B);

   assign full    = (fill_q == DEPTH_F);
   assign avg_cur = BIN_W'(sum_q >> L);
   assign jump    = {1'b0, abs_diff(bin, avg_cur)} > JUMP_B;

   // Stage 2: history, running sum and miss tracking
   always_comb begin
      hist_d       = hist_q;
      wr_ptr_d     = wr_ptr_q;
      sum_d        = sum_q;
      fill_d       = fill_q;
      miss_d       = miss_q;
      dist_valid_d = dist_valid_q;
      oor_d        = oor_q;
      upd_avg      = 1'b0;
      flush        = 1'b0;
      if (acc) begin
         miss_d = '0;
         oor_d  = 1'b0;
         if (full && jump) begin
            hist_d[0]    = bin;
            wr_ptr_d     = L'(1);
            sum_d        = SUM_W'(bin);
            fill_d       = 5'd1;
            dist_valid_d = 1'b0;
         end else if (full) begin
            // when full the write pointer sits on the oldest entry
            hist_d[wr_ptr_q] = bin;
            wr_ptr_d         = wr_ptr_q + L'(1);
            sum_d            = sum_q - SUM_W'(hist_q[wr_ptr_q]) + SUM_W'(bin);
            upd_avg          = 1'b1;
         end else begin
            hist_d[wr_ptr_q] = bin;
            wr_ptr_d         = wr_ptr_q + L'(1);
            sum_d            = sum_q + SUM_W'(bin);
            fill_d           = fill_q + 5'd1;
            if (fill_d == DEPTH_F) begin
               dist_valid_d = 1'b1;
               upd_avg      = 1'b1;
            end
         end
      end else if (smp_q.live) begin
         if (miss_q < MISS_MAX)
            miss_d = miss_q + MISS_W'(1);
         if (miss_d == MISS_MAX) begin
            flush        = 1'b1;
            for (int i = 0; i < DEPTH; i++)
               hist_d[i] = '0;
            wr_ptr_d     = '0;
            sum_d        = '0;
            fill_d       = '0;
            dist_valid_d = 1'b0;
            oor_d        = 1'b1;
         end
      end
   end

   assign avg_new = BIN_W'(sum_d >> L);

   bcd_bin_to_bcd u_bin_to_bcd (
      .bin_in  (avg_new),
      .bcd_out (avg_bcd)
   );

   always_comb begin
      dist_bcd_d = dist_bcd_q;
      if (flush)
         dist_bcd_d = FLUSH_BCD;
      else if (upd_avg)
         dist_bcd_d = avg_bcd;
   end

   always_ff @(posedge clk_34 or posedge reset) begin
      if (reset) begin
         smp_q        <= '0;
         for (int i = 0; i < DEPTH; i++)
            hist_q[i] <= '0;
         wr_ptr_q     <= '0;
         sum_q        <= '0;
         fill_q       <= '0;
         miss_q       <= '0;
         dist_bcd_q   <= FLUSH_BCD;
         dist_valid_q <= 1'b0;
         oor_q        <= 1'b0;
      end else begin
         smp_q        <= smp_d;
         hist_q       <= hist_d;
         wr_ptr_q     <= wr_ptr_d;
         sum_q        <= sum_d;
         fill_q       <= fill_d;
         miss_q       <= miss_d;
         dist_bcd_q   <= dist_bcd_d;
         dist_valid_q <= dist_valid_d;
         oor_q        <= oor_d;
      end
   end

   assign dist_bcd     = dist_bcd_q;
   assign dist_valid   = dist_valid_q;
   assign out_of_range = oor_q;
   assign fill_level   = fill_q;

endmodule
